// File: rtl/ttl_pattern_gen_pkg.sv
// Shared definitions for the TTL pattern sequencer: FSM encoding and health codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ttl_pattern_gen_pkg;

  // Sequencer states; LOAD and DONE each last exactly one cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // health_o codes. BAD_LEN clears on the next accepted arm; WR_ACTIVE is sticky until then.
  localparam logic [1:0] HEALTH_OK        = 2'd0;
  localparam logic [1:0] HEALTH_BAD_LEN   = 2'd1;
  localparam logic [1:0] HEALTH_WR_ACTIVE = 2'd2;

  // A table entry is packed as {delta, value}: value sits in the low NCHAN bits and
  // delta occupies the DELTA_W bits directly above it.

endpackage

// File: rtl/ttl_pattern_table.sv
// Pattern table RAM: DEPTH x WIDTH, one write port and one registered read port.
// Latency: read data appears one cycle after rd_en; a write is visible to a read on the following cycle.
// Backpressure: none; both ports accept every cycle.
module ttl_pattern_table #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 38,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Plain RAM: no reset, so it maps onto block memory; read-during-write returns old data.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ttl_pattern_gen.sv
// N-channel TTL sequencer: plays {hold, value} table entries onto ttl_o with repeat count and done pulse.
// Latency: ttl_o shows entry 0 two cycles after the arm cycle; entries follow back-to-back with no gaps.
// Backpressure: none; arm while active is ignored, and table writes while active are dropped and flagged.
module ttl_pattern_gen
  import ttl_pattern_gen_pkg::*;
#(
  parameter int NCHAN   = 6,
  parameter int DEPTH   = 32,
  parameter int DELTA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tbl_wr_i,
  input  logic [$clog2(DEPTH)-1:0]   tbl_addr_i,
  input  logic [DELTA_W+NCHAN-1:0]   tbl_data_i,
  input  logic [$clog2(DEPTH):0]     length_i,
  input  logic [15:0]                repeats_i,
  input  logic                       arm_i,
  input  logic                       disarm_i,
  output logic [NCHAN-1:0]           ttl_o,
  output logic                       active_o,
  output logic                       done_o,
  output logic [1:0]                 health_o,
  output logic [15:0]                pass_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DELTA_W + NCHAN;

  state_t             state;
  logic [AW:0]        len_q;
  logic [15:0]        reps_q;
  logic [AW-1:0]      cur_idx;   // entry currently driven on ttl_o
  logic [AW-1:0]      pf_idx;    // entry currently held in rd_data (prefetched)
  logic [DELTA_W-1:0] hold_cnt;  // remaining cycles after the current one

  logic [EW-1:0]      rd_data;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [AW-1:0]      pf_next;
  logic [DELTA_W-1:0] rd_delta;
  logic [DELTA_W-1:0] rd_hold;
  logic [NCHAN-1:0]   rd_value;
  logic               last_cycle;
  logic               pass_end;
  logic               run_done;
  logic [16:0]        pass_inc;
  logic               len_ok;

  // Next table index within the latched pass length, wrapping to 0 after the last entry.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] idx, input logic [AW:0] len);
    if (({1'b0, idx} + (AW+1)'(1)) >= len) return '0;
    else return idx + AW'(1);
  endfunction

  ttl_pattern_table #(.DEPTH(DEPTH), .WIDTH(EW), .AW(AW)) u_table (
    .clk_i   (clk_i),
    .wr_en   (tbl_wr_i && (state == ST_IDLE)),
    .wr_addr (tbl_addr_i),
    .wr_data (tbl_data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Entry decode, prefetch addressing and pass-end detection.
  always_comb begin
    rd_delta   = rd_data[EW-1:NCHAN];
    rd_value   = rd_data[NCHAN-1:0];
    rd_hold    = (rd_delta == '0) ? '0 : rd_delta - DELTA_W'(1);
    pf_next    = wrap_inc(pf_idx, len_q);
    last_cycle = (state == ST_RUN) && (hold_cnt == '0);
    pass_end   = last_cycle && ({1'b0, cur_idx} == (len_q - (AW+1)'(1)));
    pass_inc   = {1'b0, pass_o} + 17'd1;
    run_done   = pass_end && (reps_q != 16'd0) && (pass_inc == {1'b0, reps_q});
    len_ok     = (length_i != '0) && (length_i <= (AW+1)'(DEPTH));
    // IDLE keeps entry 0 staged so the arm->LOAD cycle already has it in rd_data.
    rd_en      = (state == ST_IDLE) || (state == ST_LOAD) || last_cycle;
    rd_addr    = (state == ST_IDLE) ? '0 : pf_next;
  end

  // Sequencer FSM with registered outputs; disarm overrides everything outside IDLE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      reps_q   <= '0;
      cur_idx  <= '0;
      pf_idx   <= '0;
      hold_cnt <= '0;
      ttl_o    <= '0;
      active_o <= 1'b0;
      done_o   <= 1'b0;
      health_o <= HEALTH_OK;
      pass_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if (tbl_wr_i && (state != ST_IDLE)) health_o <= HEALTH_WR_ACTIVE;
      case (state)
        ST_IDLE: begin
          if (arm_i && !disarm_i) begin
            if (len_ok) begin
              len_q    <= length_i;
              reps_q   <= repeats_i;
              health_o <= HEALTH_OK;
              pass_o   <= '0;
              pf_idx   <= '0;
              active_o <= 1'b1;
              state    <= ST_LOAD;
            end else begin
              health_o <= HEALTH_BAD_LEN;
            end
          end
        end
        ST_LOAD: begin
          ttl_o    <= rd_value;
          hold_cnt <= rd_hold;
          cur_idx  <= pf_idx;
          pf_idx   <= pf_next;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          if (last_cycle) begin
            if (pass_end && (pass_o != 16'hFFFF)) pass_o <= pass_o + 16'd1;
            if (run_done) begin
              ttl_o    <= '0;
              active_o <= 1'b0;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              ttl_o    <= rd_value;
              hold_cnt <= rd_hold;
              cur_idx  <= pf_idx;
              pf_idx   <= pf_next;
            end
          end else begin
            hold_cnt <= hold_cnt - DELTA_W'(1);
          end
        end
        ST_DONE: begin
          ttl_o    <= '0;
          active_o <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (disarm_i && (state != ST_IDLE)) begin
        ttl_o    <= '0;
        active_o <= 1'b0;
        done_o   <= 1'b0;
        state    <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ttl_pattern_gen.sv
// Directed bench for ttl_pattern_gen: playback timing, repeats, disarm, health flags and async reset.
// Latency: cycle k below means k cycles after the arm cycle, sampled 1 ns after the rising edge.
// Backpressure: n/a.
module tb_ttl_pattern_gen;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        tbl_wr_i = 1'b0;
  logic [4:0]  tbl_addr_i = '0;
  logic [37:0] tbl_data_i = '0;
  logic [5:0]  length_i = '0;
  logic [15:0] repeats_i = '0;
  logic        arm_i = 1'b0;
  logic        disarm_i = 1'b0;
  logic [5:0]  ttl_o;
  logic        active_o;
  logic        done_o;
  logic [1:0]  health_o;
  logic [15:0] pass_o;

  int errors = 0;
  int checks = 0;

  ttl_pattern_gen #(.NCHAN(6), .DEPTH(32), .DELTA_W(32)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .tbl_wr_i   (tbl_wr_i),
    .tbl_addr_i (tbl_addr_i),
    .tbl_data_i (tbl_data_i),
    .length_i   (length_i),
    .repeats_i  (repeats_i),
    .arm_i      (arm_i),
    .disarm_i   (disarm_i),
    .ttl_o      (ttl_o),
    .active_o   (active_o),
    .done_o     (done_o),
    .health_o   (health_o),
    .pass_o     (pass_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [5:0] v);
    tbl_wr_i = 1'b1; tbl_addr_i = a; tbl_data_i = {d, v};
    tick();
    tbl_wr_i = 1'b0;
  endtask

  // Arm in the current cycle (cycle 0); returns in cycle 1.
  task automatic do_arm(input logic [5:0] len, input logic [15:0] reps);
    length_i = len; repeats_i = reps; arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({ttl_o, active_o, done_o, health_o, pass_o} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state ttl=%h act=%b done=%b health=%0d pass=%0d expected all zero",
               ttl_o, active_o, done_o, health_o, pass_o);
    end
  endtask

  task automatic test_single_pass();
    logic [5:0] exp_ttl;
    wr(5'd0, 32'd3, 6'h01);
    wr(5'd1, 32'd2, 6'h05);
    do_arm(6'd2, 16'd1);
    checks++;
    if (active_o !== 1'b1 || ttl_o !== 6'h00) begin
      errors++;
      $display("FAIL single_c1 act=%b ttl=%h expected act=1 ttl=00", active_o, ttl_o);
    end
    for (int k = 2; k <= 8; k++) begin
      tick();
      exp_ttl = (k <= 4) ? 6'h01 : (k <= 6) ? 6'h05 : 6'h00;
      checks++;
      if (ttl_o !== exp_ttl || done_o !== (k == 7) || active_o !== (k <= 6)) begin
        errors++;
        $display("FAIL single_c%0d ttl=%h done=%b act=%b expected ttl=%h done=%b act=%b",
                 k, ttl_o, done_o, active_o, exp_ttl, (k == 7), (k <= 6));
      end
    end
  endtask

  task automatic test_repeats();
    logic [5:0] exp_ttl;
    int dones = 0;
    do_arm(6'd2, 16'd3);
    for (int k = 2; k <= 19; k++) begin
      tick();
      if (done_o === 1'b1) dones++;
      exp_ttl = (k >= 17) ? 6'h00 : (((k - 2) % 5) < 3) ? 6'h01 : 6'h05;
      checks++;
      if (ttl_o !== exp_ttl) begin
        errors++;
        $display("FAIL repeats_ttl_c%0d got=%h expected=%h", k, ttl_o, exp_ttl);
      end
      if (k == 7 || k == 12 || k == 17) begin
        checks++;
        if (pass_o !== 16'((k - 2) / 5)) begin
          errors++;
          $display("FAIL repeats_pass_c%0d got=%0d expected=%0d", k, pass_o, (k - 2) / 5);
        end
      end
      if (k == 17) begin
        checks++;
        if (done_o !== 1'b1) begin
          errors++;
          $display("FAIL repeats_done_c17 got=%b expected=1", done_o);
        end
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL repeats_done_count got=%0d expected=1", dones);
    end
  endtask

  task automatic test_write_while_active();
    bit seen = 0;
    do_arm(6'd2, 16'd1);
    tick();
    wr(5'd0, 32'd7, 6'h3F);
    checks++;
    if (health_o !== 2'd2 || ttl_o !== 6'h01) begin
      errors++;
      $display("FAIL wr_active_flag health=%0d ttl=%h expected health=2 ttl=01", health_o, ttl_o);
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || health_o !== 2'd2) begin
      errors++;
      $display("FAIL wr_active_done seen=%0d health=%0d expected seen=1 health=2", seen, health_o);
    end
    tick();
    do_arm(6'd2, 16'd1);
    checks++;
    if (health_o !== 2'd0) begin
      errors++;
      $display("FAIL wr_rearm_health got=%0d expected=0", health_o);
    end
    tick();
    checks++;
    if (ttl_o !== 6'h01) begin
      errors++;
      $display("FAIL wr_replay_c2 got=%h expected=01", ttl_o);
    end
    tick(); tick();
    checks++;
    if (ttl_o !== 6'h01) begin
      errors++;
      $display("FAIL wr_replay_c4 got=%h expected=01", ttl_o);
    end
    tick();
    checks++;
    if (ttl_o !== 6'h05) begin
      errors++;
      $display("FAIL wr_replay_c5 got=%h expected=05", ttl_o);
    end
    repeat (4) tick();
  endtask

  task automatic test_infinite_disarm();
    int dones = 0;
    bit act_drop = 0;
    do_arm(6'd2, 16'd0);
    for (int k = 2; k <= 101; k++) begin
      tick();
      if (done_o === 1'b1) dones++;
      if (active_o !== 1'b1) act_drop = 1;
    end
    checks++;
    if (pass_o !== 16'd19 || ttl_o !== 6'h05 || act_drop) begin
      errors++;
      $display("FAIL inf_c101 pass=%0d ttl=%h act_drop=%0d expected pass=19 ttl=05 act_drop=0",
               pass_o, ttl_o, act_drop);
    end
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    checks++;
    if (ttl_o !== 6'h00 || active_o !== 1'b0) begin
      errors++;
      $display("FAIL inf_disarm ttl=%h act=%b expected ttl=00 act=0", ttl_o, active_o);
    end
    repeat (3) begin
      tick();
      if (done_o === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL inf_no_done got=%0d pulses expected=0", dones);
    end
  endtask

  task automatic test_reset_midrun();
    do_arm(6'd2, 16'd0);
    repeat (7) tick();
    #3 reset_i = 1'b1;
    #1;
    checks++;
    if ({ttl_o, active_o, done_o, health_o, pass_o} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset ttl=%h act=%b done=%b health=%0d pass=%0d expected all zero",
               ttl_o, active_o, done_o, health_o, pass_o);
    end
    tick();
    reset_i = 1'b0;
    tick(); tick();
    do_arm(6'd2, 16'd1);
    tick();
    checks++;
    if (ttl_o !== 6'h01) begin
      errors++;
      $display("FAIL post_reset_c2 got=%h expected=01", ttl_o);
    end
    tick(); tick(); tick();
    checks++;
    if (ttl_o !== 6'h05) begin
      errors++;
      $display("FAIL post_reset_c5 got=%h expected=05", ttl_o);
    end
    tick(); tick();
    checks++;
    if (done_o !== 1'b1 || ttl_o !== 6'h00) begin
      errors++;
      $display("FAIL post_reset_c7 done=%b ttl=%h expected done=1 ttl=00", done_o, ttl_o);
    end
    repeat (3) tick();
  endtask

  task automatic test_delta_zero();
    logic [5:0] exp_ttl;
    wr(5'd0, 32'd0, 6'h2A);
    wr(5'd1, 32'd2, 6'h15);
    do_arm(6'd2, 16'd1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      exp_ttl = (k == 2) ? 6'h2A : (k <= 4) ? 6'h15 : 6'h00;
      checks++;
      if (ttl_o !== exp_ttl || done_o !== (k == 5)) begin
        errors++;
        $display("FAIL delta0_c%0d ttl=%h done=%b expected ttl=%h done=%b",
                 k, ttl_o, done_o, exp_ttl, (k == 5));
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_bad_length();
    do_arm(6'd0, 16'd1);
    checks++;
    if (health_o !== 2'd1 || active_o !== 1'b0) begin
      errors++;
      $display("FAIL len0 health=%0d act=%b expected health=1 act=0", health_o, active_o);
    end
    tick();
    do_arm(6'd33, 16'd1);
    checks++;
    if (health_o !== 2'd1 || active_o !== 1'b0) begin
      errors++;
      $display("FAIL len33 health=%0d act=%b expected health=1 act=0", health_o, active_o);
    end
    tick();
    do_arm(6'd1, 16'd1);
    checks++;
    if (health_o !== 2'd0 || active_o !== 1'b1) begin
      errors++;
      $display("FAIL len1_arm health=%0d act=%b expected health=0 act=1", health_o, active_o);
    end
    tick();
    checks++;
    if (ttl_o !== 6'h2A) begin
      errors++;
      $display("FAIL len1_c2 got=%h expected=2A", ttl_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || pass_o !== 16'd1) begin
      errors++;
      $display("FAIL len1_c3 done=%b pass=%0d expected done=1 pass=1", done_o, pass_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_arm_disarm_same_cycle();
    length_i = 6'd2; repeats_i = 16'd1;
    arm_i = 1'b1; disarm_i = 1'b1;
    tick();
    arm_i = 1'b0; disarm_i = 1'b0;
    tick(); tick();
    checks++;
    if (active_o !== 1'b0 || ttl_o !== 6'h00) begin
      errors++;
      $display("FAIL arm_disarm act=%b ttl=%h expected act=0 ttl=00", active_o, ttl_o);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    test_reset();
    #1 reset_i = 1'b0;
    tick();
    test_single_pass();
    test_repeats();
    test_write_while_active();
    test_infinite_disarm();
    test_reset_midrun();
    test_delta_zero();
    test_bad_length();
    test_arm_disarm_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
